// File: rtl/clock_gate_controller_if.sv
// Control/status bundle between the run sequencer and the compute clock gate.
// The master side drives run requests and stall requests; the slave side reports gating status.
interface clock_gate_controller_if #(
    parameter int NUM_SOURCES = 2,
    parameter int COUNT_W     = 48
) ();
    logic                   locked;
    logic                   start;
    logic [COUNT_W-1:0]     cycle_limit;
    logic                   abort;
    logic [NUM_SOURCES-1:0] stall_req;
    logic [NUM_SOURCES-1:0] stall_ack;
    logic                   compute_clock_en;
    logic                   busy;
    logic                   done;
    logic [COUNT_W-1:0]     cycle_count;

    modport master (
        output locked, start, cycle_limit, abort, stall_req,
        input  stall_ack, compute_clock_en, busy, done, cycle_count
    );

    modport slave (
        input  locked, start, cycle_limit, abort, stall_req,
        output stall_ack, compute_clock_en, busy, done, cycle_count
    );
endinterface

// File: rtl/clock_gate_controller.sv
// Runs the compute clock for a programmed number of enabled cycles.
// Supports per-source stall handshakes, abort, and PLL-lock gating.
module clock_gate_controller #(
    parameter int NUM_SOURCES = 2,
    parameter int COUNT_W     = 48
) (
    input  logic                    control_clock,
    input  logic                    sync_rst_n,
    clock_gate_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, STALL, FINISH} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [COUNT_W-1:0]     limit_q;
    logic [COUNT_W-1:0]     count_q;
    logic                   en_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NUM_SOURCES-1:0] ack_q;
    logic                   accept;
    logic                   halt;
    logic                   limit_hit;
    logic                   any_req;

    // Losing PLL lock mid-run is handled exactly like an abort.
    assign halt      = bus.abort || !bus.locked;
    assign limit_hit = (count_q + COUNT_W'(1)) == limit_q;
    assign any_req   = |bus.stall_req;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && bus.locked) begin
                    accept = 1'b1;
                    if (bus.cycle_limit == '0) begin
                        state_d = FINISH;
                    end else if (any_req) begin
                        state_d = STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (halt || limit_hit) begin
                    state_d = FINISH;
                end else if (any_req) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                // Resume only once every requester has released and seen its ack drop.
                if (halt) begin
                    state_d = FINISH;
                end else if (!any_req && (ack_q == '0)) begin
                    state_d = RUN;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge control_clock or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= '0;
            limit_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= (state_d == RUN);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FINISH);
            ack_q   <= bus.stall_req & {NUM_SOURCES{!en_q && (state_q != RUN)}};
            if (accept) begin
                limit_q <= bus.cycle_limit;
                count_q <= '0;
            end else if (en_q) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign bus.compute_clock_en = en_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.stall_ack        = ack_q;
    assign bus.cycle_count      = count_q;
endmodule
